prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 159 +++++++++++++++
 tb/tb_prog_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: receives count, opcode/operand pairs and a checksum,
// writes 16-bit words into program memory, then releases the CPU until HALT.
module prog_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        halt,
    output logic        rom_we,
    output logic [7:0]  rom_addr,
    output logic [15:0] rom_wdata,
    output logic        cpu_run,
    output logic        load_done,
    output logic [2:0]  err_code
);

    typedef enum logic [2:0] {IDLE, COUNT, OPC, OPR, CHK, RUN, ERR} state_t;

    localparam logic [2:0] ERR_ZERO_COUNT = 3'd1;
    localparam logic [2:0] ERR_BAD_OPCODE = 3'd2;
    localparam logic [2:0] ERR_CHECKSUM   = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT    = 3'd4;
    localparam logic [7:0] MAX_OPCODE     = 8'h1C;

    state_t      state_reg;
    logic        rx_ready_reg;
    logic        rom_we_reg;
    logic [7:0]  rom_addr_reg;
    logic [15:0] rom_wdata_reg;
    logic        cpu_run_reg;
    logic        load_done_reg;
    logic [2:0]  err_code_reg;
    logic [7:0]  count_reg;
    logic [7:0]  opcode_reg;
    logic [7:0]  index_reg;
    logic [7:0]  chk_reg;
    logic [7:0]  idle_reg;

    logic       accept;
    logic [7:0] chk_next;
    logic       last_operand;
    logic       timeout;

    assign accept       = rx_valid && rx_ready_reg;
    assign chk_next     = chk_reg ^ rx_data;
    assign last_operand = (index_reg + 8'd1) == count_reg;
    // An accepted byte on the would-be 255th idle cycle wins over the timeout.
    assign timeout      = rx_ready_reg && !accept && (idle_reg == 8'd254);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            rx_ready_reg  <= 1'b0;
            rom_we_reg    <= 1'b0;
            rom_addr_reg  <= 8'd0;
            rom_wdata_reg <= 16'd0;
            cpu_run_reg   <= 1'b0;
            load_done_reg <= 1'b0;
            err_code_reg  <= 3'd0;
            count_reg     <= 8'd0;
            opcode_reg    <= 8'd0;
            index_reg     <= 8'd0;
            chk_reg       <= 8'd0;
            idle_reg      <= 8'd0;
        end else begin
            rom_we_reg    <= 1'b0;
            load_done_reg <= 1'b0;
            if (rx_ready_reg) begin
                idle_reg <= accept ? 8'd0 : idle_reg + 8'd1;
            end

            case (state_reg)
                IDLE, ERR: begin
                    if (start) begin
                        state_reg    <= COUNT;
                        rx_ready_reg <= 1'b1;
                        err_code_reg <= 3'd0;
                        index_reg    <= 8'd0;
                        chk_reg      <= 8'd0;
                        idle_reg     <= 8'd0;
                    end
                end
                COUNT: begin
                    if (accept) begin
                        if (rx_data == 8'd0) begin
                            state_reg    <= ERR;
                            rx_ready_reg <= 1'b0;
                            err_code_reg <= ERR_ZERO_COUNT;
                        end else begin
                            state_reg <= OPC;
                            count_reg <= rx_data;
                            chk_reg   <= chk_next;
                        end
                    end
                end
                OPC: begin
                    if (accept) begin
                        if (rx_data > MAX_OPCODE) begin
                            state_reg    <= ERR;
                            rx_ready_reg <= 1'b0;
                            err_code_reg <= ERR_BAD_OPCODE;
                        end else begin
                            state_reg  <= OPR;
                            opcode_reg <= rx_data;
                            chk_reg    <= chk_next;
                        end
                    end
                end
                OPR: begin
                    if (accept) begin
                        rom_we_reg    <= 1'b1;
                        rom_addr_reg  <= index_reg;
                        rom_wdata_reg <= {opcode_reg, rx_data};
                        index_reg     <= index_reg + 8'd1;
                        chk_reg       <= chk_next;
                        state_reg     <= last_operand ? CHK : OPC;
                    end
                end
                CHK: begin
                    if (accept) begin
                        rx_ready_reg <= 1'b0;
                        if (rx_data == chk_reg) begin
                            state_reg     <= RUN;
                            load_done_reg <= 1'b1;
                            cpu_run_reg   <= 1'b1;
                        end else begin
                            state_reg    <= ERR;
                            err_code_reg <= ERR_CHECKSUM;
                        end
                    end
                end
                RUN: begin
                    if (halt) begin
                        state_reg   <= IDLE;
                        cpu_run_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (timeout) begin
                state_reg    <= ERR;
                rx_ready_reg <= 1'b0;
                err_code_reg <= ERR_TIMEOUT;
            end
        end
    end

    assign rx_ready  = rx_ready_reg;
    assign rom_we    = rom_we_reg;
    assign rom_addr  = rom_addr_reg;
    assign rom_wdata = rom_wdata_reg;
    assign cpu_run   = cpu_run_reg;
    assign load_done = load_done_reg;
    assign err_code  = err_code_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected writes, load_done pulses and error codes
// are queued by the stimulus and checked by an independent monitor.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        halt = 1'b0;
    logic        rom_we;
    logic [7:0]  rom_addr;
    logic [15:0] rom_wdata;
    logic        cpu_run;
    logic        load_done;
    logic [2:0]  err_code;

    prog_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .halt      (halt),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_wdata (rom_wdata),
        .cpu_run   (cpu_run),
        .load_done (load_done),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] K_WRITE = 2'd0;
    localparam logic [1:0] K_DONE  = 2'd1;
    localparam logic [1:0] K_ERR   = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [23:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_writes = 0;
    logic [2:0] prev_err = 3'd0;

    task automatic expect_ev(input logic [1:0] kind, input logic [23:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic match(input string name, input logic [1:0] kind, input logic [23:0] val);
        exp_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("[%0t] FAIL %s: unexpected event kind=%0d val=%06h, none required", $time, name, kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val) begin
                n_bad++;
                $display("[%0t] FAIL %s: got kind=%0d val=%06h, required kind=%0d val=%06h",
                         $time, name, kind, val, e.kind, e.val);
            end else begin
                $display("[%0t] ok   %s: kind=%0d val=%06h", $time, name, kind, val);
            end
        end
    endtask

    // Monitor: samples DUT outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rom_we) begin
            n_writes++;
            match("rom_write", K_WRITE, {rom_addr, rom_wdata});
        end
        if (load_done) match("load_done", K_DONE, 24'd0);
        if (err_code != prev_err && err_code != 3'd0) match("err_code", K_ERR, {21'd0, err_code});
        prev_err = err_code;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("[%0t] FAIL %s: got %0h, required %0h", $time, name, act, req);
        end else begin
            $display("[%0t] ok   %s: %0h", $time, name, act);
        end
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        while (!rx_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_ready) begin
            check("rx_ready_wait", 32'(rx_ready), 32'd1);
        end else begin
            rx_valid = 1'b1;
            rx_data  = b;
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_seq(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outputs"}, {22'd0, rx_ready, rom_we, cpu_run, load_done, err_code, 3'd0}, 32'd0);
        check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        check({tag, "_rom_wdata"}, 32'(rom_wdata), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[%0t] FAIL watchdog: simulation did not finish, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        @(negedge clk);
        do_reset();
        check_all_zero("reset");

        // Good two-word load: checksum 02^13^05^0E^00 = 1A
        pulse_start();
        check("count_rx_ready", 32'(rx_ready), 32'd1);
        expect_ev(K_WRITE, {8'd0, 16'h1305});
        expect_ev(K_WRITE, {8'd1, 16'h0E00});
        expect_ev(K_DONE, 24'd0);
        send_seq('{8'h02, 8'h13, 8'h05, 8'h0E, 8'h00, 8'h1A});
        check("good_cpu_run", 32'(cpu_run), 32'd1);
        check("good_rx_ready", 32'(rx_ready), 32'd0);
        check("good_err_code", 32'(err_code), 32'd0);

        // HALT in RUN returns to IDLE
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        check("halt_cpu_run", 32'(cpu_run), 32'd0);
        pulse_start();
        check("halt_idle_start", 32'(rx_ready), 32'd1);

        // Reset in the cycle an operand is accepted drops the write
        send_seq('{8'h01, 8'h13});
        rx_valid = 1'b1;
        rx_data  = 8'h07;
        reset    = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        reset    = 1'b0;
        check_all_zero("mid_opr_reset");
        repeat (3) @(negedge clk);
        check("mid_opr_no_we", 32'(rom_we), 32'd0);

        // Bad checksum 1B: two writes still happen
        w0 = n_writes;
        pulse_start();
        expect_ev(K_WRITE, {8'd0, 16'h1305});
        expect_ev(K_WRITE, {8'd1, 16'h0E00});
        expect_ev(K_ERR, 24'd3);
        send_seq('{8'h02, 8'h13, 8'h05, 8'h0E, 8'h00, 8'h1B});
        check("chk_err_code", 32'(err_code), 32'd3);
        check("chk_cpu_run", 32'(cpu_run), 32'd0);
        check("chk_rx_ready", 32'(rx_ready), 32'd0);
        check("chk_write_count", 32'(n_writes - w0), 32'd2);

        // Zero count from ERR, then a good one-word load: 01^13^07 = 15
        pulse_start();
        check("restart_err_clear", 32'(err_code), 32'd0);
        expect_ev(K_ERR, 24'd1);
        send_byte(8'h00);
        check("zero_err_code", 32'(err_code), 32'd1);
        pulse_start();
        expect_ev(K_WRITE, {8'd0, 16'h1307});
        expect_ev(K_DONE, 24'd0);
        send_seq('{8'h01, 8'h13, 8'h07, 8'h15});
        check("one_cpu_run", 32'(cpu_run), 32'd1);
        do_reset();
        check("reset_from_run", 32'(cpu_run), 32'd0);

        // Bad opcode 1D, no write
        w0 = n_writes;
        pulse_start();
        expect_ev(K_ERR, 24'd2);
        send_seq('{8'h01, 8'h1D});
        check("opc_err_code", 32'(err_code), 32'd2);
        check("opc_write_count", 32'(n_writes - w0), 32'd0);

        // Timeout after 255 idle cycles
        pulse_start();
        send_byte(8'h01);
        repeat (254) @(negedge clk);
        check("idle254_err_code", 32'(err_code), 32'd0);
        check("idle254_rx_ready", 32'(rx_ready), 32'd1);
        expect_ev(K_ERR, 24'd4);
        @(negedge clk);
        check("timeout_err_code", 32'(err_code), 32'd4);
        check("timeout_rx_ready", 32'(rx_ready), 32'd0);

        // Byte on the 255th idle cycle wins: 01^13^05 = 17
        pulse_start();
        send_byte(8'h01);
        repeat (254) @(negedge clk);
        send_byte(8'h13);
        check("late_byte_err_code", 32'(err_code), 32'd0);
        check("late_byte_rx_ready", 32'(rx_ready), 32'd1);
        expect_ev(K_WRITE, {8'd0, 16'h1305});
        expect_ev(K_DONE, 24'd0);
        send_seq('{8'h05, 8'h17});
        check("late_byte_cpu_run", 32'(cpu_run), 32'd1);

        repeat (4) @(negedge clk);
        check("pending_events", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
